// File: rtl/ps2_rx_deframer.sv
`timescale 1ns/1ps
// ps2_rx_deframer
// Deframes device-to-host PS/2 frames (start, 8 data LSB-first, odd parity,
// stop) from raw pad levels and emits validated scan codes as one-cycle
// strobes. Reception is gated by RX_EN so init responses are never emitted.
//
// Optional build macro: PS2_BREAK_FILTER_EN
//   When defined, an accepted F0 arms a break-pending flag and the following
//   non-E0 byte is swallowed together with the F0 (no KEY_VALID, KEY_VALUE
//   untouched). E0 always passes through.
//
// State table:
//   IDLE   | waiting for a start bit on the next PS/2 falling edge
//   DATA   | shifting in the 8 data bits, LSB first
//   PARITY | latching the odd-parity bit
//   STOP   | latching the stop bit, then accept or reject the frame
module ps2_rx_deframer #(
  parameter int unsigned CLK_HZ         = 40000000,
  parameter int unsigned TIMEOUT_CYCLES = 80000,
  parameter int unsigned SYNC_STAGES    = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RX_EN,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic [7:0] KEY_VALUE,
  output logic       KEY_VALID,
  output logic       FRAME_ERR,
  output logic       RX_BUSY
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Reject configurations the synchronizer and timer cannot support.
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2 || CLK_HZ == 0) begin : g_cfg_check
    $error("ps2_rx_deframer: SYNC_STAGES must be >= 2, TIMEOUT_CYCLES >= 2, CLK_HZ > 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   fall_stb;
  logic                   data_s;

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
`ifdef PS2_BREAK_FILTER_EN
  logic          break_pending;
`endif

  // Synchronize both pads, detect the clock falling edge, and delay data by
  // one cycle so the sampled bit lines up with the registered fall strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      fall_stb  <= 1'b0;
      data_s    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK_IN};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_DATA_IN};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
      fall_stb  <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      data_s    <= data_sync[SYNC_STAGES-1];
    end
  end

  // Frame FSM with inter-edge timeout; all outputs are registered here.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
      KEY_VALUE  <= 8'h00;
      KEY_VALID  <= 1'b0;
      FRAME_ERR  <= 1'b0;
      RX_BUSY    <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      break_pending <= 1'b0;
`endif
    end else begin
      KEY_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (!RX_EN) begin
        // Gated: drop any partial frame silently.
        state   <= IDLE;
        bit_cnt <= 3'd0;
        to_cnt  <= '0;
        RX_BUSY <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        break_pending <= 1'b0;
`endif
      end else if (fall_stb) begin
        // A falling edge always wins over a simultaneous timeout.
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
              shift   <= 8'h00;
              RX_BUSY <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              break_pending <= 1'b0;
`endif
            end
          end
          DATA: begin
            shift <= {data_s, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            parity_bit <= data_s;
            state      <= STOP;
          end
          STOP: begin
            state   <= IDLE;
            RX_BUSY <= 1'b0;
            if ((((^shift) ^ parity_bit) == 1'b1) && data_s) begin
`ifdef PS2_BREAK_FILTER_EN
              if (shift == 8'hE0) begin
                KEY_VALUE <= shift;
                KEY_VALID <= 1'b1;
              end else if (break_pending) begin
                break_pending <= 1'b0;
              end else if (shift == 8'hF0) begin
                break_pending <= 1'b1;
              end else begin
                KEY_VALUE <= shift;
                KEY_VALID <= 1'b1;
              end
`else
              KEY_VALUE <= shift;
              KEY_VALID <= 1'b1;
`endif
            end else begin
              FRAME_ERR <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
              break_pending <= 1'b0;
`endif
            end
          end
          default: begin
            state   <= IDLE;
            RX_BUSY <= 1'b0;
          end
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TO_LAST) begin
          // Stalled frame: discard the partial byte and report it.
          state     <= IDLE;
          to_cnt    <= '0;
          bit_cnt   <= 3'd0;
          shift     <= 8'h00;
          FRAME_ERR <= 1'b1;
          RX_BUSY   <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
          break_pending <= 1'b0;
`endif
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_deframer.sv
`timescale 1ns/1ps
// Testbench for ps2_rx_deframer: directed and random PS/2 frames checked
// against a frame-level reference model (expected strobe counts, last value,
// and the full sequence of emitted scan codes).
module tb_ps2_rx_deframer;

  localparam int SYNC = 3;
  localparam int TMO  = 400;
  localparam int H    = 20;   // PS/2 half-period in system clocks

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       RX_EN;
  logic       PS2_CLK_IN;
  logic       PS2_DATA_IN;
  logic [7:0] KEY_VALUE;
  logic       KEY_VALID;
  logic       FRAME_ERR;
  logic       RX_BUSY;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int last_fall_cyc = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int kv_lat = -1;
  int fe_lat = -1;
  logic prev_kv = 1'b0;
  logic prev_fe = 1'b0;
  logic [7:0] kv_log[$];

  int exp_kv_cnt = 0;
  int exp_fe_cnt = 0;
  logic [7:0] exp_key = 8'h00;
  logic [7:0] exp_log[$];
`ifdef PS2_BREAK_FILTER_EN
  bit pending = 1'b0;
`endif

  ps2_rx_deframer #(
    .CLK_HZ(40000000),
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .RX_EN(RX_EN),
    .PS2_CLK_IN(PS2_CLK_IN),
    .PS2_DATA_IN(PS2_DATA_IN),
    .KEY_VALUE(KEY_VALUE),
    .KEY_VALID(KEY_VALID),
    .FRAME_ERR(FRAME_ERR),
    .RX_BUSY(RX_BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling system clock edge.
  always @(negedge CLK) begin
    if (KEY_VALID === 1'b1) begin
      kv_cnt++;
      kv_log.push_back(KEY_VALUE);
      kv_lat = cyc - last_fall_cyc;
    end
    if (FRAME_ERR === 1'b1) begin
      fe_cnt++;
      fe_lat = cyc - last_fall_cyc;
    end
    if (KEY_VALID === 1'b1 || FRAME_ERR === 1'b1) begin
      check("strobe_exclusive", 32'(KEY_VALID & FRAME_ERR), 32'd0);
      check("strobe_one_cycle", 32'((KEY_VALID & prev_kv) | (FRAME_ERR & prev_fe)), 32'd0);
    end
    prev_kv = KEY_VALID;
    prev_fe = FRAME_ERR;
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed no finish expected finish before 600us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference model: frame-level outcome from the protocol rules.
  task automatic model_error();
    exp_fe_cnt++;
`ifdef PS2_BREAK_FILTER_EN
    pending = 1'b0;
`endif
  endtask

  task automatic model_emit(input logic [7:0] d);
    exp_kv_cnt++;
    exp_key = d;
    exp_log.push_back(d);
  endtask

  task automatic model_frame(input logic [7:0] d, input bit good);
    if (!good) begin
      model_error();
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (d == 8'hE0) model_emit(d);
      else if (pending) pending = 1'b0;
      else if (d == 8'hF0) pending = 1'b1;
      else model_emit(d);
`else
      model_emit(d);
`endif
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par, input bit stop);
    logic par;
    par = (~^d) ^ bad_par;
    return {stop, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DATA_IN = bits[i];
      tick(H);
      PS2_CLK_IN = 1'b0;
      last_fall_cyc = cyc;
      tick(H);
      PS2_CLK_IN = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop);
    send_bits(mk(d, bad_par, stop), 11);
    PS2_DATA_IN = 1'b1;
    tick(H + 10);
    model_frame(d, !bad_par && stop);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_kv_count"}, kv_cnt, exp_kv_cnt);
    check({tag, "_fe_count"}, fe_cnt, exp_fe_cnt);
    check({tag, "_key_value"}, 32'(KEY_VALUE), 32'(exp_key));
    check({tag, "_busy_idle"}, 32'(RX_BUSY), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int r;
    int n;

    RESET_N = 1'b0;
    RX_EN = 1'b0;
    PS2_CLK_IN = 1'b1;
    PS2_DATA_IN = 1'b1;
    tick(3);
    check("reset_key_value", 32'(KEY_VALUE), 32'd0);
    check("reset_key_valid", 32'(KEY_VALID), 32'd0);
    check("reset_frame_err", 32'(FRAME_ERR), 32'd0);
    check("reset_rx_busy", 32'(RX_BUSY), 32'd0);
    RESET_N = 1'b1;
    RX_EN = 1'b1;
    tick(5);

    send_frame(8'h1C, 1'b0, 1'b1);
    check_state("good_1c");
    check("kv_latency", kv_lat, SYNC + 2);

    send_frame(8'h1C, 1'b1, 1'b1);
    check_state("bad_parity");
    check("fe_latency", fe_lat, SYNC + 2);

    send_frame(8'h33, 1'b0, 1'b0);
    check_state("bad_stop");

    send_bits(11'h7FF, 1);
    tick(H);
    model_error();
    check_state("bad_start");

    send_bits(mk(8'h55, 1'b0, 1'b1), 5);
    PS2_DATA_IN = 1'b1;
    check("timeout_busy_mid", 32'(RX_BUSY), 32'd1);
    check("timeout_no_err_yet", fe_cnt, exp_fe_cnt);
    tick(TMO + 50);
    model_error();
    check_state("timeout");
    check("timeout_window", 32'(fe_lat >= TMO && fe_lat <= TMO + SYNC + 4), 32'd1);
    send_frame(8'h29, 1'b0, 1'b1);
    check_state("after_timeout_29");

    send_bits(mk(8'h44, 1'b0, 1'b1), 3);
    RX_EN = 1'b0;
    tick(2);
    check("rxen_drop_busy", 32'(RX_BUSY), 32'd0);
    PS2_DATA_IN = 1'b1;
    tick(H);
    send_bits(mk(8'hFA, 1'b0, 1'b1), 11);
    PS2_DATA_IN = 1'b1;
    tick(H + 10);
    check_state("rxen_low_fa");
    RX_EN = 1'b1;
    tick(5);
    send_frame(8'h75, 1'b0, 1'b1);
    check_state("rxen_high_75");

    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h72, 1'b0, 1'b1);
    check_state("break_seq");

    send_bits(mk(8'h3C, 1'b0, 1'b1), 4);
    RESET_N = 1'b0;
    #2;
    check("midreset_key_value", 32'(KEY_VALUE), 32'd0);
    check("midreset_key_valid", 32'(KEY_VALID), 32'd0);
    check("midreset_frame_err", 32'(FRAME_ERR), 32'd0);
    check("midreset_rx_busy", 32'(RX_BUSY), 32'd0);
    exp_key = 8'h00;
`ifdef PS2_BREAK_FILTER_EN
    pending = 1'b0;
`endif
    PS2_CLK_IN = 1'b1;
    PS2_DATA_IN = 1'b1;
    tick(3);
    RESET_N = 1'b1;
    tick(5);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_state("after_reset_5a");

    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      r = int'($urandom_range(0, 3));
      send_frame(d, r == 0, r != 1);
      check_state("random");
    end

    check("log_length", kv_log.size(), exp_log.size());
    n = (kv_log.size() < exp_log.size()) ? kv_log.size() : exp_log.size();
    for (int i = 0; i < n; i++) begin
      check("log_entry", 32'(kv_log[i]), 32'(exp_log[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
